word_packer: RTL

Upstream feeder for the 64-bit `fifo`. It accepts narrow samples on a valid/ready stream and packs them LSB-first into `OUT_WIDTH`-bit words. Each completed word is pushed into the FIFO using the FIFO's own `w_valid`/`fifo_full` protocol. Partial words are flushed on `in_last` and zero-padded, so a narrow producer (e.g. a 16-bit sensor or compute stage) can share the FIFO's full datapath width.

---
 rtl/word_packer_pkg.sv | 26 ++
 rtl/word_packer_if.sv | 31 +++
 rtl/word_packer.sv | 105 ++++++++++
 3 files changed

// File: rtl/word_packer_pkg.sv
// Shared definitions for the word packer and its matching downstream unpacker:
// default widths, the FSM state type and lane-count sizing helpers.
package packer_pkg;

  localparam int DEF_IN_WIDTH  = 16;
  localparam int DEF_OUT_WIDTH = 64;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } pack_state_e;

  function automatic int calc_ratio(input int in_w, input int out_w);
    return out_w / in_w;
  endfunction

  // Lane counts run 1..RATIO, so they need one bit more than a lane index.
  function automatic int lane_width(input int ratio);
    return $clog2(ratio) + 1;
  endfunction

  function automatic int cnt_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/word_packer_if.sv
// Sample stream in, packed-word FIFO push out. The slave side is the packer;
// the master side is its environment (producer plus FIFO).
interface word_packer_if
  import packer_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
);
  localparam int LANE_W = lane_width(calc_ratio(IN_WIDTH, OUT_WIDTH));

  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_last;
  logic                 fifo_full;
  logic                 w_valid;
  logic [OUT_WIDTH-1:0] data_in;
  logic [LANE_W-1:0]    pack_lanes;
  logic                 pack_last;

  modport slave (
    input  in_valid, in_data, in_last, fifo_full,
    output in_ready, w_valid, data_in, pack_lanes, pack_last
  );

  modport master (
    output in_valid, in_data, in_last, fifo_full,
    input  in_ready, w_valid, data_in, pack_lanes, pack_last
  );

endinterface

// File: rtl/word_packer.sv
// Packs narrow samples LSB-first into FIFO-width words, flushing on in_last,
// with one output word plus one stalled word of backpressure capacity.
module word_packer
  import packer_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  word_packer_if.slave  bus
);

  localparam int RATIO  = calc_ratio(IN_WIDTH, OUT_WIDTH);
  localparam int LANE_W = lane_width(RATIO);
  localparam int CNT_W  = cnt_width(RATIO);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  pack_state_e          r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [OUT_WIDTH-1:0] r_acc;
  logic [LANE_W-1:0]    r_acc_lanes;
  logic                 r_acc_last;
  logic [OUT_WIDTH-1:0] r_out_data;
  logic [LANE_W-1:0]    r_out_lanes;
  logic                 r_out_last;
  logic                 r_out_pend;

  logic                 w_ready;
  logic                 w_push;
  logic                 w_can_xfer;
  logic                 w_accept;
  logic                 w_complete;
  logic [LANE_W-1:0]    w_lanes;
  logic [OUT_WIDTH-1:0] w_word;

  assign w_ready    = rst_n && (r_state == FILL);
  assign w_push     = r_out_pend && !bus.fifo_full;
  assign w_can_xfer = !r_out_pend || w_push;
  assign w_accept   = bus.in_valid && w_ready;
  assign w_complete = w_accept && ((r_cnt == LAST_LANE) || bus.in_last);
  assign w_lanes    = LANE_W'(r_cnt) + LANE_W'(1);

  // Upper lanes are already zero because the accumulator is cleared on every hand-off.
  always_comb begin
    w_word = r_acc;
    w_word[int'(r_cnt)*IN_WIDTH +: IN_WIDTH] = bus.in_data;
  end

  assign bus.in_ready   = w_ready;
  assign bus.w_valid    = w_push;
  assign bus.data_in    = r_out_data;
  assign bus.pack_lanes = r_out_lanes;
  assign bus.pack_last  = r_out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_acc_lanes <= '0;
      r_acc_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_lanes <= '0;
      r_out_last  <= 1'b0;
      r_out_pend  <= 1'b0;
    end else begin
      // A transfer below re-asserts out_pend, so this clear only sticks without one.
      if (w_push) r_out_pend <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_complete && w_can_xfer) begin
            r_out_data  <= w_word;
            r_out_lanes <= w_lanes;
            r_out_last  <= bus.in_last;
            r_out_pend  <= 1'b1;
            r_cnt       <= '0;
            r_acc       <= '0;
          end else if (w_complete) begin
            r_acc       <= w_word;
            r_acc_lanes <= w_lanes;
            r_acc_last  <= bus.in_last;
            r_state     <= STALL;
          end else if (w_accept) begin
            r_acc <= w_word;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STALL: begin
          if (w_can_xfer) begin
            r_out_data  <= r_acc;
            r_out_lanes <= r_acc_lanes;
            r_out_last  <= r_acc_last;
            r_out_pend  <= 1'b1;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_state     <= FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule
